// File: rtl/xgmii_pkg.sv
// Shared XGMII character constants, aligner state encoding and lane helpers.
package xgmii_pkg;

  localparam logic [7:0]  CH_IDLE   = 8'h07;
  localparam logic [7:0]  CH_START  = 8'hFB;
  localparam logic [7:0]  CH_TERM   = 8'hFD;
  localparam logic [7:0]  CH_ERR    = 8'hFE;
  localparam logic [71:0] IDLE_WORD = 72'hFF_0707070707070707;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FRAME    = 3'd1,
    ST_FRAME_SH = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DROP     = 3'd4
  } state_e;

  // One bit per lane: lane carries control character ch.
  function automatic logic [7:0] char_mask(input logic [71:0] w, input logic [7:0] ch);
    char_mask = {w[71] && (w[63:56] == ch), w[70] && (w[55:48] == ch),
                 w[69] && (w[47:40] == ch), w[68] && (w[39:32] == ch),
                 w[67] && (w[31:24] == ch), w[66] && (w[23:16] == ch),
                 w[65] && (w[15:8]  == ch), w[64] && (w[7:0]   == ch)};
  endfunction

  // Lane 0 carries a Start control character.
  function automatic logic is_start0(input logic [71:0] w);
    is_start0 = w[64] && (w[7:0] == CH_START);
  endfunction

  // Lanes 4-7 with their ctrl bits, packed as {ctrl[7:4], data[63:32]}.
  function automatic logic [35:0] upper_half(input logic [71:0] w);
    upper_half = {w[71:68], w[63:32]};
  endfunction

  // Realigned word: held lanes 4-7 of the previous input become lanes 0-3,
  // lanes 0-3 of the current input become lanes 4-7.
  function automatic logic [71:0] shift_word(input logic [71:0] cur, input logic [35:0] held);
    shift_word = {cur[67:64], held[35:32], cur[31:0], held[31:0]};
  endfunction

endpackage

// File: rtl/xgmii_stat_cnt.sv
// Saturating statistics counter with synchronous clear (clear wins).
module xgmii_stat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/xgmii_rx_align72.sv
// XGMII RX aligner: moves lane-4 Starts to lane 0, trims idles, flags frames
// and keeps saturating good/error frame counts.
module xgmii_rx_align72
  import xgmii_pkg::*;
#(
  parameter int IDLE_KEEP = 4,
  parameter bit LANE4_EN  = 1'b1,
  parameter int STATS_W   = 32
) (
  input  logic               xgmii_rx_clk,
  input  logic               sys_rst_n,
  input  logic [71:0]        xgmii_rxd,
  input  logic               clr_stats,
  output logic [71:0]        dout,
  output logic               dout_valid,
  output logic               sof,
  output logic               eof,
  output logic               frame_err,
  output logic [STATS_W-1:0] frame_cnt,
  output logic [STATS_W-1:0] err_cnt
);

  localparam int IC_W = $clog2(IDLE_KEEP + 2);
  localparam logic [IC_W-1:0] KEEP_C = IC_W'(IDLE_KEEP);

  state_e          state_q, state_d;
  logic [35:0]     hold_q, hold_d;
  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            sticky_q, sticky_d;
  logic [71:0]     dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            ferr_q, ferr_d;

  logic [7:0]      start_m, term_m, err_m;
  logic [71:0]     sh_word;
  logic            sh_err;

  assign start_m = char_mask(xgmii_rxd, CH_START);
  assign term_m  = char_mask(xgmii_rxd, CH_TERM);
  assign err_m   = char_mask(xgmii_rxd, CH_ERR);
  assign sh_word = shift_word(xgmii_rxd, hold_q);
  assign sh_err  = |char_mask(sh_word, CH_ERR);

  // Next-state and next-output decode for the alignment FSM.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idle_cnt_d = idle_cnt_q;
    sticky_d   = sticky_q;
    dout_d     = xgmii_rxd;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_m[0]) begin
          state_d  = ST_FRAME;
          valid_d  = 1'b1;
          sof_d    = 1'b1;
          sticky_d = |err_m;
        end else if (LANE4_EN && start_m[4]) begin
          // Start word itself is not output; it surfaces realigned next cycle.
          state_d  = ST_FRAME_SH;
          hold_d   = upper_half(xgmii_rxd);
          sticky_d = 1'b0;
        end else if (xgmii_rxd == IDLE_WORD) begin
          if (idle_cnt_q < KEEP_C) begin
            valid_d    = 1'b1;
            idle_cnt_d = idle_cnt_q + IC_W'(1);
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_DROP;
          ferr_d  = 1'b1;
        end
      end
      ST_FRAME: begin
        valid_d = 1'b1;
        if (|start_m) begin
          eof_d      = 1'b1;
          ferr_d     = 1'b1;
          state_d    = ST_DROP;
          idle_cnt_d = '0;
        end else if (|term_m) begin
          eof_d      = 1'b1;
          ferr_d     = sticky_q | (|err_m);
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else begin
          sticky_d = sticky_q | (|err_m);
        end
      end
      ST_FRAME_SH: begin
        dout_d  = sh_word;
        valid_d = 1'b1;
        sof_d   = is_start0(sh_word);
        hold_d  = upper_half(xgmii_rxd);
        if (|start_m) begin
          eof_d      = 1'b1;
          ferr_d     = 1'b1;
          state_d    = ST_DROP;
          idle_cnt_d = '0;
        end else if (|term_m[3:0]) begin
          eof_d      = 1'b1;
          ferr_d     = sticky_q | sh_err;
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end else if (|term_m[7:4]) begin
          // Terminate sits in the held half; it comes out on the flush word.
          sticky_d = sticky_q | sh_err;
          state_d  = ST_FLUSH;
        end else begin
          sticky_d = sticky_q | sh_err;
        end
      end
      ST_FLUSH: begin
        dout_d     = sh_word;
        valid_d    = 1'b1;
        eof_d      = 1'b1;
        hold_d     = upper_half(xgmii_rxd);
        idle_cnt_d = '0;
        if (start_m[0]) begin
          ferr_d  = 1'b1;
          state_d = ST_DROP;
        end else if (LANE4_EN && start_m[4]) begin
          ferr_d   = sticky_q | sh_err;
          sticky_d = 1'b0;
          state_d  = ST_FRAME_SH;
        end else begin
          ferr_d  = sticky_q | sh_err;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (xgmii_rxd == IDLE_WORD) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, hold register and registered outputs.
  always_ff @(posedge xgmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      idle_cnt_q <= '0;
      sticky_q   <= 1'b0;
      dout_q     <= IDLE_WORD;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idle_cnt_q <= idle_cnt_d;
      sticky_q   <= sticky_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ferr_q     <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_err  = ferr_q;

  xgmii_stat_cnt #(.W(STATS_W)) u_frame_cnt (
    .clk_i  (xgmii_rx_clk),
    .rst_ni (sys_rst_n),
    .clr_i  (clr_stats),
    .inc_i  (eof_d && !ferr_d),
    .cnt_o  (frame_cnt)
  );

  xgmii_stat_cnt #(.W(STATS_W)) u_err_cnt (
    .clk_i  (xgmii_rx_clk),
    .rst_ni (sys_rst_n),
    .clr_i  (clr_stats),
    .inc_i  (ferr_d),
    .cnt_o  (err_cnt)
  );

endmodule

// File: tb/tb_xgmii_rx_align72.sv
// Directed bench for xgmii_rx_align72; a second instance with 2-bit
// counters shares the stimulus for the saturation checks.
module tb_xgmii_rx_align72;

  localparam logic [71:0] IDLE_W = 72'hFF_0707070707070707;
  localparam logic [71:0] S0 = 72'h01_DDCCBBAA998877FB;
  localparam logic [71:0] T3 = 72'hF8_07070707FD333231;
  localparam logic [71:0] S4 = 72'h1F_A7A6A5FB07070707;
  localparam logic [71:0] E1 = 72'h00_B7B6B5B4B3B2B1B0;
  localparam logic [71:0] E2 = 72'h00_C7C6C5C4C3C2C1C0;
  localparam logic [71:0] T2 = 72'hFC_0707070707FDD1D0;
  localparam logic [71:0] T5 = 72'hE0_0707FDF4F3F2F1F0;
  localparam logic [71:0] EW = 72'h08_17161514FE121110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [71:0] rxd;

  logic [71:0] dout, dout_s;
  logic        dout_valid, sof, eof, frame_err;
  logic        valid_s, sof_s, eof_s, ferr_s;
  logic [31:0] fcnt, ecnt;
  logic [1:0]  fcnt_s, ecnt_s;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xgmii_rx_align72 dut (
    .xgmii_rx_clk (clk),
    .sys_rst_n    (rst_n),
    .xgmii_rxd    (rxd),
    .clr_stats    (clr),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .sof          (sof),
    .eof          (eof),
    .frame_err    (frame_err),
    .frame_cnt    (fcnt),
    .err_cnt      (ecnt)
  );

  xgmii_rx_align72 #(.STATS_W(2)) dut_s (
    .xgmii_rx_clk (clk),
    .sys_rst_n    (rst_n),
    .xgmii_rxd    (rxd),
    .clr_stats    (clr),
    .dout         (dout_s),
    .dout_valid   (valid_s),
    .sof          (sof_s),
    .eof          (eof_s),
    .frame_err    (ferr_s),
    .frame_cnt    (fcnt_s),
    .err_cnt      (ecnt_s)
  );

  task automatic check_val(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] pk(input logic v, input logic s, input logic e,
                                     input logic f, input logic [71:0] w);
    pk = {v, s, e, f, w};
  endfunction

  function automatic logic [75:0] obs();
    obs = {dout_valid, sof, eof, frame_err, dout};
  endfunction

  function automatic logic [71:0] dw(input int i);
    dw = {8'h00, 64'h0102030405060708 + 64'(i)};
  endfunction

  // Present one word; return 1 ns after the edge that registers its output.
  task automatic send(input logic [71:0] w);
    rxd = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = IDLE_W;
    clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_out", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, IDLE_W));
    check_val("rst_cnt", {fcnt, ecnt}, 64'd0);
  endtask

  task automatic good_frame();
    send(S0);
    send(dw(0));
    send(T3);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    rxd   = IDLE_W;

    // Lane-0 frame: straight pass-through, then idle trimming.
    do_reset();
    send(IDLE_W);
    check_val("t1_idle0", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, IDLE_W));
    send(S0);
    check_val("t1_sof", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, S0));
    for (int i = 0; i < 8; i++) begin
      send(dw(i));
      check_val("t1_data", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, dw(i)));
    end
    send(T3);
    check_val("t1_eof", obs(), pk(1'b1, 1'b0, 1'b1, 1'b0, T3));
    check_val("t1_fcnt", fcnt, 32'd1);
    for (int i = 0; i < 10; i++) begin
      send(IDLE_W);
      check_val("t1_idle_valid", dout_valid, (i < 4) ? 1'b1 : 1'b0);
    end
    check_val("t1_ecnt", ecnt, 32'd0);

    // Lane-4 frame ending with Terminate in lane 2: no flush word.
    do_reset();
    send(S4);
    check_val("t2_hold", dout_valid, 1'b0);
    send(E1);
    check_val("t2_sof", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 72'h01_B3B2B1B0A7A6A5FB));
    send(E2);
    check_val("t2_data", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 72'h00_C3C2C1C0B7B6B5B4));
    send(T2);
    check_val("t2_eof", obs(), pk(1'b1, 1'b0, 1'b1, 1'b0, 72'hC0_07FDD1D0C7C6C5C4));
    check_val("t2_fcnt", fcnt, 32'd1);
    send(IDLE_W);
    check_val("t2_no_flush", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, IDLE_W));

    // Lane-4 frame ending in lane 5, followed back-to-back by another.
    do_reset();
    send(S4);
    check_val("t3_hold", dout_valid, 1'b0);
    send(E1);
    check_val("t3_sof1", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 72'h01_B3B2B1B0A7A6A5FB));
    send(T5);
    check_val("t3_pre_flush", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 72'h00_F3F2F1F0B7B6B5B4));
    send(S4);
    check_val("t3_flush", obs(), pk(1'b1, 1'b0, 1'b1, 1'b0, 72'hFE_070707070707FDF4));
    check_val("t3_fcnt1", fcnt, 32'd1);
    send(E2);
    check_val("t3_sof2", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 72'h01_C3C2C1C0A7A6A5FB));
    send(T2);
    check_val("t3_eof2", obs(), pk(1'b1, 1'b0, 1'b1, 1'b0, 72'hC0_07FDD1D0C7C6C5C4));
    check_val("t3_fcnt2", fcnt, 32'd2);

    // Error handling: 0xFE in a frame, lane-0 Start during flush, junk in idle.
    do_reset();
    send(S0);
    check_val("t4_sof", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, S0));
    send(EW);
    check_val("t4_errword", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, EW));
    send(dw(0));
    send(T3);
    check_val("t4_err_eof", obs(), pk(1'b1, 1'b0, 1'b1, 1'b1, T3));
    check_val("t4_cnt1", {fcnt, ecnt}, {32'd0, 32'd1});
    send(S4);
    send(E1);
    check_val("t4_sof2", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, 72'h01_B3B2B1B0A7A6A5FB));
    send(T5);
    send(S0);
    check_val("t4_flush_viol", obs(), pk(1'b1, 1'b0, 1'b1, 1'b1, 72'h1E_998877FB0707FDF4));
    check_val("t4_cnt2", {fcnt, ecnt}, {32'd0, 32'd2});
    send(dw(1));
    check_val("t4_drop_a", dout_valid, 1'b0);
    send(dw(2));
    check_val("t4_drop_b", dout_valid, 1'b0);
    send(T3);
    check_val("t4_drop_c", dout_valid, 1'b0);
    send(IDLE_W);
    check_val("t4_drop_exit", dout_valid, 1'b0);
    send(IDLE_W);
    check_val("t4_idle_after", dout_valid, 1'b1);
    send(dw(3));
    check_val("t4_junk", {dout_valid, frame_err}, 2'b01);
    check_val("t4_cnt3", {fcnt, ecnt}, {32'd0, 32'd3});
    send(IDLE_W);
    check_val("t4_junk_exit", dout_valid, 1'b0);

    // Saturation on the 2-bit instance, then clear colliding with an eof.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      good_frame();
      check_val("t5_sat", fcnt_s, (k < 3) ? 2'(k) : 2'd3);
    end
    check_val("t5_wide", fcnt, 32'd5);
    send(S0);
    send(dw(0));
    clr = 1'b1;
    send(T3);
    clr = 1'b0;
    check_val("t5_clr_eof", eof, 1'b1);
    check_val("t5_clr_s", fcnt_s, 2'd0);
    check_val("t5_clr_w", fcnt, 32'd0);
    good_frame();
    check_val("t5_after_clr", fcnt_s, 2'd1);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    good_frame();
    check_val("t6_fcnt_pre", fcnt, 32'd1);
    send(S0);
    send(dw(0));
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_out", obs(), pk(1'b0, 1'b0, 1'b0, 1'b0, IDLE_W));
    check_val("t6_rst_cnt", {fcnt, ecnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(IDLE_W);
    check_val("t6_idle", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, IDLE_W));
    send(S0);
    check_val("t6_sof", obs(), pk(1'b1, 1'b1, 1'b0, 1'b0, S0));
    send(dw(1));
    check_val("t6_data", obs(), pk(1'b1, 1'b0, 1'b0, 1'b0, dw(1)));
    send(T3);
    check_val("t6_eof", obs(), pk(1'b1, 1'b0, 1'b1, 1'b0, T3));
    check_val("t6_cnt", {fcnt, ecnt}, {32'd1, 32'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xgmii_rx_align72.md
Name: xgmii_rx_align72

Overview:
- Parametrised successor to the XGMII RX idle-gap/lane-4 aligner.
- Takes raw 72-bit XGMII receive words and always presents frames with Start on lane 0.
- Trims inter-frame idles to a configurable count and marks which output words are valid.
- Adds SOF/EOF/error flags and saturating statistics counters; sits between the XGMII PHY interface and the RX FIFO write side.

Parameters:
- IDLE_KEEP, 4, idle words forwarded (dout_valid=1) after each frame; further idles are suppressed; 0 suppresses all idles.
- LANE4_EN, 1, 1 = accept Start on lane 4 and realign; 0 = treat a lane-4 Start as an error.
- STATS_W, 32, width of frame_cnt/err_cnt.

Ports:
- xgmii_rx_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- xgmii_rxd  in  72  {ctrl[7:0], data[63:0]}; lane i = data[8i+7:8i], ctrl bit 64+i.
- clr_stats  in  1  synchronous clear of both counters.
- dout  out  72  aligned word, same packing.
- dout_valid  out  1  dout is frame data or a kept idle.
- sof  out  1  dout carries Start (0xFB) on lane 0.
- eof  out  1  dout carries Terminate (0xFD).
- frame_err  out  1  one-cycle pulse, coincides with eof or drop.
- frame_cnt  out  STATS_W  good frames, saturating.
- err_cnt  out  STATS_W  errored or dropped frames, saturating.

Behaviour:
- Characters: Idle 0x07, Start 0xFB, Terminate 0xFD, Error 0xFE (ctrl bit = 1). Idle word = 72'hFF_0707070707070707.
- Reset, async: dout = idle word; dout_valid, sof, eof, frame_err = 0; counters = 0; state = IDLE; hold register cleared.
  - Reset asserted mid-frame discards the frame with no count.
- Latency: 1 cycle unshifted. Shifted: output n+1 = {in(n) lanes 0-3, held lanes 4-7 of in(n-1)}, with ctrl packed the same way.
- States:
  - IDLE:
    - Lane-0 Start -> FRAME. Output the word, sof=1.
    - Lane-4 Start with LANE4_EN -> FRAME_SH. Hold upper half, dout_valid=0 this cycle; sof on the next output.
    - Idle word -> forward if idle_cnt < IDLE_KEEP, else dout_valid=0. idle_cnt saturates.
    - Any other word -> DROP, frame_err pulse.
  - FRAME: pass through. Terminate in any lane -> eof, IDLE, idle_cnt=0.
  - FRAME_SH:
    - Shifted pass-through.
    - Terminate in lanes 0-3 -> eof on that output, IDLE.
    - Terminate in lanes 4-7 -> FLUSH.
  - FLUSH:
    - Output {in lanes 0-3, held}, eof=1.
    - Input lane-4 Start -> hold it, FRAME_SH (back-to-back).
    - Input lane-0 Start -> protocol violation: frame_err, DROP.
    - Otherwise -> IDLE.
  - DROP: dout_valid=0 until an all-idle word, then IDLE.
- Error rules:
  - Start while in FRAME/FRAME_SH: eof+frame_err on that word, DROP.
  - Any 0xFE in a frame sets a sticky flag, reported as frame_err with eof.
- Counters: frame_cnt +1 on eof without error; err_cnt +1 on every frame_err pulse.
  - clr_stats has priority over an increment in the same cycle.
  - Both counters saturate at all-ones.

Decomposition:
- Package xgmii_pkg: character constants (IDLE/START/TERM/ERR), IDLE_WORD, state enum, lane-extract helper functions.
- One sub-module: xgmii_stat_cnt (saturating counter with clear), instantiated twice.

Test Plan:
- Lane-0 frame:
  - Stimulus: idle, Start@lane0 + 8 data words, T@lane3, then 10 idles.
  - Response: outputs identical at 1-cycle latency; sof/eof once; 4 idles valid then valid=0; frame_cnt=1.
- Lane-4 frame, T@lane2:
  - Stimulus: Start@lane4 word, then data, then a word with T in lane 2.
  - Response: first valid output has 0xFB in data[7:0] with ctrl bit 64 set; eof on the output holding 0xFD; no FLUSH cycle.
- Lane-4 frame, T@lane5, back-to-back:
  - Stimulus: T in lane 5, next word idles on lanes 0-3 with Start@lane4.
  - Response: FLUSH word has eof; next output has sof; frame_cnt=2.
- Errors:
  - Stimulus: 0xFE mid-frame; second frame has a lane-0 Start during FLUSH.
  - Response: frame_err with eof; err_cnt=1, then 2; dropped frame produces no valid output.
- Saturation/clear:
  - Stimulus: STATS_W=2 with 5 good frames, then clr_stats in the same cycle as an eof.
  - Response: frame_cnt holds 3, then reads 0.
- Async reset:
  - Stimulus: sys_rst_n low mid-frame.
  - Response: dout = idle word immediately, valid=0, counters 0; next lane-0 frame is aligned correctly.
